// File: rtl/cofi_vblend_if.sv
// Pixel bus between the horizontal cofi blender and the vertical blend stage.
// The stage sees the slave view; whoever drives pixels in uses the master view.
interface cofi_vblend_if #(
  parameter int ADDR_W = 10
);
  logic              ce_pixel;
  logic              enable;
  logic              debug_view;
  logic              hblank;
  logic              vblank;
  logic              hsync;
  logic              vsync;
  logic [7:0]        red;
  logic [7:0]        green;
  logic [7:0]        blue;
  logic              hblank_out;
  logic              vblank_out;
  logic              hsync_out;
  logic              vsync_out;
  logic [7:0]        red_out;
  logic [7:0]        green_out;
  logic [7:0]        blue_out;
  logic [ADDR_W:0]   line_width;
  logic              overflow;

  modport slave (
    input  ce_pixel, enable, debug_view, hblank, vblank, hsync, vsync,
           red, green, blue,
    output hblank_out, vblank_out, hsync_out, vsync_out,
           red_out, green_out, blue_out, line_width, overflow
  );

  modport master (
    output ce_pixel, enable, debug_view, hblank, vblank, hsync, vsync,
           red, green, blue,
    input  hblank_out, vblank_out, hsync_out, vsync_out,
           red_out, green_out, blue_out, line_width, overflow
  );
endinterface

// File: rtl/cofi_vblend.sv
// Vertical cofi blend: averages each active pixel with the one directly above
// it (held in a one-line buffer) when all channels are within DIFF_THRESH.
// Two-stage pipeline; sync/blank travel alongside the pixel.
module cofi_vblend #(
  parameter int MAX_WIDTH   = 1024,
  parameter int ADDR_W      = 10,
  parameter int DIFF_THRESH = 32
) (
  input  logic            clk,
  input  logic            reset,
  cofi_vblend_if.slave    vb
);

  typedef enum logic [1:0] {VBL, HBL, LINE} state_t;

  localparam logic [ADDR_W:0] MAX_X = MAX_WIDTH[ADDR_W:0];

  state_t            state;
  logic [ADDR_W:0]   x;
  logic [ADDR_W:0]   prev_width;
  logic              prev_valid;
  logic              vblank_d;
  logic [ADDR_W:0]   line_width_q;
  logic              overflow_q;

  logic [23:0]       line_buf [MAX_WIDTH];
  logic [23:0]       rd_data;

  // Stage 1: pixel as received plus the blend eligibility known at that time
  logic [23:0]       s1_cur;
  logic              s1_cand;
  logic              s1_active;
  logic              s1_debug;
  logic              s1_hb, s1_vb, s1_hs, s1_vs;

  // Stage 2: registered outputs
  logic [23:0]       out_rgb;
  logic              out_hb, out_vb, out_hs, out_vs;

  logic              active;
  logic              take_pixel;
  logic              in_range;
  logic              wr_en;
  logic [ADDR_W-1:0] addr;

  assign active     = ~vb.hblank & ~vb.vblank;
  assign take_pixel = active & (state != VBL);
  assign in_range   = x < MAX_X;
  assign wr_en      = vb.ce_pixel & ~reset & take_pixel & in_range;
  assign addr       = in_range ? x[ADDR_W-1:0] : '0;

  function automatic logic near(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    d = (a > b) ? a - b : b - a;
    return int'(d) <= DIFF_THRESH;
  endfunction

  function automatic logic [7:0] avg(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8:1];
  endfunction

  // Line buffer: read-first, so the read returns the previous line's pixel
  // NOTE: the buffer is deliberately not reset; its contents are only used
  // once prev_valid says a full line has been written since reset.
  always_ff @(posedge clk) begin
    if (vb.ce_pixel) begin
      rd_data <= line_buf[addr];
      if (wr_en) line_buf[addr] <= {vb.red, vb.green, vb.blue};
    end
  end

  // Line tracking FSM: column counter, previous-line width and overflow
  // NOTE: all state uses non-blocking assignment so every register samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= VBL;
      x            <= '0;
      prev_width   <= '0;
      prev_valid   <= 1'b0;
      vblank_d     <= 1'b1;
      line_width_q <= '0;
      overflow_q   <= 1'b0;
    end else if (vb.ce_pixel) begin
      vblank_d <= vb.vblank;
      unique case (state)
        VBL: begin
          prev_valid <= 1'b0;
          x          <= '0;
          if (vblank_d & ~vb.vblank) state <= HBL;
        end
        HBL: begin
          if (vb.vblank) begin
            state <= VBL;
            x     <= '0;
          end else if (active) begin
            state <= LINE;
            x     <= x + 1'b1;
          end
        end
        LINE: begin
          if (vb.vblank) begin
            state <= VBL;
            x     <= '0;
          end else if (vb.hblank) begin
            line_width_q <= x;
            prev_width   <= x;
            if (x != '0) prev_valid <= 1'b1;
            x            <= '0;
            state        <= HBL;
          end else if (in_range) begin
            x <= x + 1'b1;
          end else begin
            overflow_q <= 1'b1;
          end
        end
        default: state <= VBL;
      endcase
    end
  end

  // Stage 1: capture pixel, timing and blend eligibility
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_cur    <= '0;
      s1_cand   <= 1'b0;
      s1_active <= 1'b0;
      s1_debug  <= 1'b0;
      s1_hb     <= 1'b1;
      s1_vb     <= 1'b1;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
    end else if (vb.ce_pixel) begin
      s1_cur    <= {vb.red, vb.green, vb.blue};
      s1_cand   <= vb.enable & prev_valid & take_pixel & in_range & (x < prev_width);
      s1_active <= active;
      s1_debug  <= vb.debug_view;
      s1_hb     <= vb.hblank;
      s1_vb     <= vb.vblank;
      s1_hs     <= vb.hsync;
      s1_vs     <= vb.vsync;
    end
  end

  logic        blend;
  logic [23:0] next_rgb;

  // Blend decision against the pixel above, or pass-through
  // NOTE: every signal gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    blend    = 1'b0;
    next_rgb = s1_cur;
    blend    = s1_cand
             & near(s1_cur[23:16], rd_data[23:16])
             & near(s1_cur[15:8],  rd_data[15:8])
             & near(s1_cur[7:0],   rd_data[7:0]);
    if (blend) begin
      next_rgb = {avg(s1_cur[23:16], rd_data[23:16]),
                  avg(s1_cur[15:8],  rd_data[15:8]),
                  avg(s1_cur[7:0],   rd_data[7:0])};
    end else if (s1_active & s1_debug) begin
      next_rgb[23:16] = 8'hFF;
    end
  end

  // Stage 2: output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      out_rgb <= '0;
      out_hb  <= 1'b1;
      out_vb  <= 1'b1;
      out_hs  <= 1'b0;
      out_vs  <= 1'b0;
    end else if (vb.ce_pixel) begin
      out_rgb <= next_rgb;
      out_hb  <= s1_hb;
      out_vb  <= s1_vb;
      out_hs  <= s1_hs;
      out_vs  <= s1_vs;
    end
  end

  assign vb.red_out    = out_rgb[23:16];
  assign vb.green_out  = out_rgb[15:8];
  assign vb.blue_out   = out_rgb[7:0];
  assign vb.hblank_out = out_hb;
  assign vb.vblank_out = out_vb;
  assign vb.hsync_out  = out_hs;
  assign vb.vsync_out  = out_vs;
  assign vb.line_width = line_width_q;
  assign vb.overflow   = overflow_q;

endmodule

// File: tb/tb_cofi_vblend.sv
// Self-checking bench for cofi_vblend: a line-level reference model checked
// every cycle, plus literal expectations on the active output pixels.
module tb_cofi_vblend;
  localparam int MAX_WIDTH   = 8;
  localparam int ADDR_W      = 4;
  localparam int DIFF_THRESH = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cofi_vblend_if #(.ADDR_W(ADDR_W)) bus ();

  cofi_vblend #(
    .MAX_WIDTH  (MAX_WIDTH),
    .ADDR_W     (ADDR_W),
    .DIFF_THRESH(DIFF_THRESH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .vb   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        hb;
    logic        vbl;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
  } vid_t;

  vid_t        m_s1, m_out;
  logic [23:0] prev_line[$];
  logic [23:0] cur_line[$];
  bit          prev_valid, in_frame, last_vb, m_ovf;
  int          m_lw;

  function automatic bit all_near(input logic [23:0] a, input logic [23:0] b);
    bit ok = 1;
    for (int c = 0; c < 3; c++) begin
      int d = int'(a[c*8 +: 8]) - int'(b[c*8 +: 8]);
      if (d < 0) d = -d;
      if (d > DIFF_THRESH) ok = 0;
    end
    return ok;
  endfunction

  function automatic logic [23:0] mix(input logic [23:0] a, input logic [23:0] b);
    logic [23:0] r;
    for (int c = 0; c < 3; c++) r[c*8 +: 8] = 8'((int'(a[c*8 +: 8]) + int'(b[c*8 +: 8])) / 2);
    return r;
  endfunction

  always @(posedge clk) begin
    vid_t        in_v;
    bit          act, bl;
    int          col;
    logic [23:0] res;
    if (reset) begin
      m_s1 = {1'b1, 1'b1, 1'b0, 1'b0, 24'h0};
      m_out = m_s1;
      prev_line.delete();
      cur_line.delete();
      prev_valid = 0; in_frame = 0; last_vb = 1; m_ovf = 0; m_lw = 0;
    end else if (bus.ce_pixel) begin
      in_v = {bus.hblank, bus.vblank, bus.hsync, bus.vsync, bus.red, bus.green, bus.blue};
      act  = !bus.hblank && !bus.vblank;
      bl   = 0;
      res  = in_v.rgb;
      if (in_frame && act) begin
        col = cur_line.size();
        if (bus.enable && prev_valid && col < prev_line.size() && col < MAX_WIDTH)
          bl = all_near(in_v.rgb, prev_line[col]);
        if (bl) res = mix(in_v.rgb, prev_line[col]);
        if (col < MAX_WIDTH) cur_line.push_back(in_v.rgb);
        else m_ovf = 1;
      end else if (in_frame && bus.vblank) begin
        in_frame = 0; prev_valid = 0; cur_line.delete();
      end else if (in_frame && bus.hblank && cur_line.size() > 0) begin
        prev_line = cur_line;
        m_lw = cur_line.size();
        prev_valid = 1;
        cur_line.delete();
      end else if (!in_frame && last_vb && !bus.vblank) begin
        in_frame = 1;
      end
      if (act && !bl && bus.debug_view) res[23:16] = 8'hFF;
      last_vb = bus.vblank;
      in_v.rgb = res;
      m_out = m_s1;
      m_s1 = in_v;
    end
  end

  // ---------------- compare process ----------------
  logic [23:0] act_q[$];

  always @(posedge clk) begin
    logic ce_s, rst_s;
    ce_s  = bus.ce_pixel;
    rst_s = reset;
    #1;
    check("pipe",
          {bus.hblank_out, bus.vblank_out, bus.hsync_out, bus.vsync_out,
           bus.red_out, bus.green_out, bus.blue_out, bus.line_width, bus.overflow},
          {m_out.hb, m_out.vbl, m_out.hs, m_out.vs, m_out.rgb,
           5'(m_lw), m_ovf});
    if (ce_s && !rst_s && !bus.hblank_out && !bus.vblank_out)
      act_q.push_back({bus.red_out, bus.green_out, bus.blue_out});
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit hb, input bit vbl, input bit hs, input bit vs,
                       input logic [23:0] rgb, input bit ce);
    bus.hblank = hb; bus.vblank = vbl; bus.hsync = hs; bus.vsync = vs;
    {bus.red, bus.green, bus.blue} = rgb;
    bus.ce_pixel = ce;
    @(negedge clk);
  endtask

  task automatic frame_start();
    drive(1, 1, 0, 0, 24'h0, 1);
    drive(1, 1, 0, 1, 24'h0, 1);
    drive(1, 1, 0, 0, 24'h0, 1);
    drive(1, 0, 0, 0, 24'h0, 1);
    drive(1, 0, 0, 0, 24'h0, 1);
  endtask

  task automatic line(input int n, input logic [23:0] rgb, input bit gap);
    drive(1, 0, 1, 0, 24'h0, 1);
    drive(1, 0, 0, 0, 24'h0, 1);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, rgb, 1);
      if (gap) drive(0, 0, 0, 0, 24'hABCDEF, 0);
    end
  endtask

  task automatic flush();
    repeat (4) drive(1, 0, 0, 0, 24'h0, 1);
  endtask

  task automatic check_run(input string name, input int start, input int cnt,
                           input logic [23:0] exp);
    for (int i = start; i < start + cnt; i++)
      if (i < act_q.size()) check(name, act_q[i], exp);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    reset = 1'b1;
    bus.enable = 1'b1;
    bus.debug_view = 1'b0;
    bus.ce_pixel = 1'b1;
    bus.hblank = 1'b1; bus.vblank = 1'b1; bus.hsync = 1'b0; bus.vsync = 1'b0;
    {bus.red, bus.green, bus.blue} = 24'h0;
    repeat (3) @(negedge clk);
    check("rst_hblank", bus.hblank_out, 1'b1);
    check("rst_vblank", bus.vblank_out, 1'b1);
    check("rst_rgb", {bus.red_out, bus.green_out, bus.blue_out}, 24'h0);
    check("rst_width", bus.line_width, 5'd0);
    check("rst_ovf", bus.overflow, 1'b0);
    reset = 1'b0;

    // uniform lines: first line untouched, second averaged
    act_q.delete();
    frame_start();
    line(8, 24'h0A141E, 0);
    line(8, 24'h1E2832, 0);
    flush();
    check("s2_count", act_q.size(), 16);
    check_run("s2_line0", 0, 8, 24'h0A141E);
    check_run("s2_line1", 8, 8, 24'h141E28);
    check("s2_width", bus.line_width, 5'd8);

    // same, with ce_pixel gaps between line1 pixels
    act_q.delete();
    frame_start();
    line(8, 24'h0A141E, 0);
    line(8, 24'h1E2832, 1);
    flush();
    check("s5_count", act_q.size(), 16);
    check_run("s5_line1", 8, 8, 24'h141E28);

    // threshold: diff 33 passes, diff 32 blends, debug marks unblended
    act_q.delete();
    frame_start(); line(1, 24'h640000, 0); line(1, 24'h850000, 0); flush();
    check_run("s3_diff33", 1, 1, 24'h850000);
    act_q.delete();
    frame_start(); line(1, 24'h640000, 0); line(1, 24'h840000, 0); flush();
    check_run("s3_diff32", 1, 1, 24'h740000);
    bus.debug_view = 1'b1;
    act_q.delete();
    frame_start(); line(1, 24'h640000, 0); line(1, 24'h850000, 0); flush();
    check_run("s3_debug", 0, 2, 24'hFF0000);
    bus.debug_view = 1'b0;

    // longer second line: extra columns pass through
    act_q.delete();
    frame_start(); line(4, 24'h000000, 0); line(6, 24'h020202, 0); flush();
    check("s4_count", act_q.size(), 10);
    check_run("s4_blend", 4, 4, 24'h010101);
    check_run("s4_extra", 8, 2, 24'h020202);

    // overflow past MAX_WIDTH
    act_q.delete();
    frame_start(); line(10, 24'h0A0A0A, 0); line(10, 24'h0C0C0C, 0); flush();
    check("s6_ovf", bus.overflow, 1'b1);
    check("s6_width", bus.line_width, 5'd8);
    check_run("s6_blend", 10, 8, 24'h0B0B0B);
    check_run("s6_over", 18, 2, 24'h0C0C0C);

    // reset mid-line clears overflow; next line unblended
    line(3, 24'h111111, 0);
    reset = 1'b1;
    drive(0, 0, 0, 0, 24'h111111, 1);
    drive(1, 0, 0, 0, 24'h0, 1);
    check("s6_rst_ovf", bus.overflow, 1'b0);
    check("s6_rst_width", bus.line_width, 5'd0);
    reset = 1'b0;
    act_q.delete();
    line(4, 24'h141414, 0); line(4, 24'h161616, 0); flush();
    check("s6_rst_count", act_q.size(), 8);
    check_run("s6_rst_first", 0, 4, 24'h141414);
    check_run("s6_rst_second", 4, 4, 24'h151515);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
